fifo_wr_ctrl: RTL

//   Write-side controller for the audio sample FIFO, parametrised in depth.

---
 rtl/fifo_wr_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side controller for the audio sample FIFO
// Gates writes on a registered full flag; keeps binary and Gray write pointers, level and overflow.
module fifo_wr_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int AFULL_THRESH = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W:0]   rptr_gray_sync,
  input  logic              clr_ovf,
  output logic              fifo_we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_bin,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam logic [ADDR_W:0] AFT = AFULL_THRESH[ADDR_W:0];

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] diff_next;
  logic [ADDR_W:0] full_cmp;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      rbin[i] = ^(rptr_gray_sync >> i);
    end
  end

  assign fifo_we    = wr & ~full & ~rst;
  assign waddr      = wptr_bin[ADDR_W-1:0];
  assign wbin_next  = wptr_bin + {{ADDR_W{1'b0}}, fifo_we};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign diff_next  = wbin_next - rbin;
  // Full in Gray space: top two bits inverted, remainder equal.
  assign full_cmp   = {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_bin    <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      level       <= '0;
      overflow    <= 1'b0;
    end else begin
      wptr_bin    <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= (wgray_next == full_cmp);
      level       <= diff_next;
      almost_full <= (diff_next >= AFT);
      if (wr && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
